pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 core. It owns the fetch-stage predicted-PC register (F_predPC), which feeds the PC-select logic. It generates the per-stage stall and bubble controls for the F/D/E/M/W pipeline registers and sequences exception drain and halt. It also keeps saturating performance counters for cycles, fetch stalls and mispredicts.

## Interface
- CNT_W, 32, width of performance counters
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- f_predPC_i  in  64  next predicted PC from fetch
- D_icode_i, E_icode_i, M_icode_i  in  4 each  icodes in D/E/M pipeline registers (define.v encodings)
- E_dstM_i  in  4  memory-load destination register of the instruction in E
- d_srcA_i, d_srcB_i  in  4 each  source registers decoded in D
- e_Cnd_i  in  1  condition result computed in execute
- m_stat_i  in  3  status produced in memory stage
- W_stat_i  in  3  status in W pipeline register
- F_predPC_o  out  64  registered predicted PC
- F_stall_o, D_stall_o, W_stall_o  out  1 each  hold pipeline register
- D_bubble_o, E_bubble_o, M_bubble_o  out  1 each  load nop/AOK bubble
- halted_o  out  1  core halted
- cycle_cnt_o, stall_cnt_o, mispred_cnt_o  out  CNT_W each  performance counters

## Operation
- Derived terms, combinational:
  - load_use = E_icode ∈ {MRMOVQ, POPQ} && E_dstM != RNONE && E_dstM ∈ {d_srcA, d_srcB}
  - ret_pend = RET ∈ {D_icode, E_icode, M_icode}
  - mispred = E_icode == JXX && !e_Cnd
  - m_exc = m_stat != AOK; w_exc = W_stat != AOK
- FSM states: RUN, DRAIN, HALT.
- Transitions:
  - RUN→HALT if w_exc (priority).
  - RUN→DRAIN if m_exc.
  - DRAIN→HALT if w_exc.
  - DRAIN holds otherwise.
  - HALT is left only by reset.
- Outputs in RUN:
  - F_stall = load_use || ret_pend
  - D_stall = load_use
  - D_bubble = mispred || (ret_pend && !load_use)
  - E_bubble = mispred || load_use
  - M_bubble = m_exc || w_exc
  - W_stall = w_exc
- Outputs in DRAIN: F_stall=1, D_bubble=1, E_bubble=1, M_bubble=1, D_stall=0, W_stall = w_exc.
- Outputs in HALT: F_stall=D_stall=W_stall=1, M_bubble=1, D_bubble=E_bubble=0, halted_o=1.
- Precedence: D_stall and D_bubble are never both 1; stall wins.
- F_predPC register: loads f_predPC_i each cycle unless F_stall_o=1; holds otherwise.
- Counters: all saturate at 2^CNT_W−1 and never wrap.
  - cycle_cnt: +1 every cycle while not in HALT.
  - stall_cnt: +1 each RUN cycle with F_stall_o=1.
  - mispred_cnt: +1 each RUN cycle with mispred=1.

## Timing
- Reset (async assert, sync to clk on deassert internally not required): state=RUN, F_predPC_o=0, all counters 0, halted_o=0.
- Control outputs are combinational from current inputs and state, valid in the same cycle.
- F_predPC_o, state and counters update on the clk rising edge.
- halted_o is registered and rises the cycle after w_exc is seen.
- Simultaneous mispred and load_use: E_bubble=1, D_stall=1, D_bubble=0, F_stall=1.
- Simultaneous mispred and ret_pend (RET in D behind a mispredicted JXX): D_bubble=1, F_stall=1; both counters that apply still increment.
- m_exc and w_exc in the same cycle: go to HALT directly.
- Reset mid-drain or in HALT returns to RUN immediately; counters clear.

## Test plan
- Reset: hold rst_n=0 with f_predPC_i=0x100 → F_predPC_o=0, all counters 0, halted_o=0. Release, 1 cycle → F_predPC_o=0x100, cycle_cnt=1.
- Load-use: E_icode=MRMOVQ, E_dstM=3, d_srcA=3 → F_stall=D_stall=E_bubble=1, D_bubble=0; F_predPC_o holds; stall_cnt +1.
- RET sequence: RET in D, then E, then M for 3 cycles → F_stall=D_bubble=1 each cycle; stall_cnt +3; with RET in W only, F_stall=0.
- Mispredict: E_icode=JXX, e_Cnd=0 → D_bubble=E_bubble=1, F_stall=0; mispred_cnt=1. Combined with load_use → D_bubble=0, D_stall=1.
- Exception: m_stat=ADR for 1 cycle → DRAIN outputs next cycle. Then W_stat=ADR → W_stall=1, then halted_o=1 with all counters frozen. Assert rst_n=0 → RUN.
- Saturation: CNT_W=4, run 20 cycles → cycle_cnt_o=15, stays 15.

Source files
------------

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - Y86-64 pipeline control: stall/bubble generation, drain/halt FSM, predicted-PC register, perf counters.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      f_predPC_i,
  input  logic [3:0]       D_icode_i,
  input  logic [3:0]       E_icode_i,
  input  logic [3:0]       M_icode_i,
  input  logic [3:0]       E_dstM_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  input  logic             e_Cnd_i,
  input  logic [2:0]       m_stat_i,
  input  logic [2:0]       W_stat_i,
  output logic [63:0]      F_predPC_o,
  output logic             F_stall_o,
  output logic             D_stall_o,
  output logic             W_stall_o,
  output logic             D_bubble_o,
  output logic             E_bubble_o,
  output logic             M_bubble_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;
  localparam logic [2:0] S_AOK    = 3'd1;

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2} state_t;

  state_t state_q, state_d;
  logic   load_use, ret_pend, mispred, m_exc, w_exc, d_bubble_raw;

  assign load_use = ((E_icode_i == I_MRMOVQ) || (E_icode_i == I_POPQ)) &&
                    (E_dstM_i != R_NONE) &&
                    ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
  assign ret_pend = (D_icode_i == I_RET) || (E_icode_i == I_RET) || (M_icode_i == I_RET);
  assign mispred  = (E_icode_i == I_JXX) && !e_Cnd_i;
  assign m_exc    = (m_stat_i != S_AOK);
  assign w_exc    = (W_stat_i != S_AOK);

  always_comb begin
    state_d      = state_q;
    F_stall_o    = 1'b0;
    D_stall_o    = 1'b0;
    W_stall_o    = 1'b0;
    d_bubble_raw = 1'b0;
    E_bubble_o   = 1'b0;
    M_bubble_o   = 1'b0;
    case (state_q)
      RUN: begin
        if (w_exc)      state_d = HALT;
        else if (m_exc) state_d = DRAIN;
        F_stall_o    = load_use || ret_pend;
        D_stall_o    = load_use;
        d_bubble_raw = mispred || (ret_pend && !load_use);
        E_bubble_o   = mispred || load_use;
        M_bubble_o   = m_exc || w_exc;
        W_stall_o    = w_exc;
      end
      DRAIN: begin
        if (w_exc) state_d = HALT;
        F_stall_o    = 1'b1;
        d_bubble_raw = 1'b1;
        E_bubble_o   = 1'b1;
        M_bubble_o   = 1'b1;
        W_stall_o    = w_exc;
      end
      HALT: begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        W_stall_o  = 1'b1;
        M_bubble_o = 1'b1;
      end
      default: state_d = RUN;
    endcase
    // A stalled D register must keep its instruction, so stall masks bubble.
    D_bubble_o = d_bubble_raw && !D_stall_o;
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      halted_o      <= 1'b0;
      F_predPC_o    <= '0;
      cycle_cnt_o   <= '0;
      stall_cnt_o   <= '0;
      mispred_cnt_o <= '0;
    end else begin
      state_q  <= state_d;
      halted_o <= (state_d == HALT);
      if (!F_stall_o) F_predPC_o <= f_predPC_i;
      if (state_q != HALT) cycle_cnt_o <= sat_inc(cycle_cnt_o);
      if (state_q == RUN && F_stall_o) stall_cnt_o <= sat_inc(stall_cnt_o);
      if (state_q == RUN && mispred) mispred_cnt_o <= sat_inc(mispred_cnt_o);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - Directed bench for pipe_ctrl with a per-cycle reference model and literal checkpoints.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] f_predPC;
  logic [3:0]  d_icode, e_icode, m_icode, e_dstM, srcA, srcB;
  logic        cnd;
  logic [2:0]  m_stat, w_stat;

  logic [63:0] pc;
  logic        fs, ds, ws, db, eb, mb, halted;
  logic [31:0] cyc, stl, mis;

  logic [63:0] pc4;
  logic        fs4, ds4, ws4, db4, eb4, mb4, halted4;
  logic [3:0]  cyc4, stl4, mis4;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n), .f_predPC_i(f_predPC),
    .D_icode_i(d_icode), .E_icode_i(e_icode), .M_icode_i(m_icode),
    .E_dstM_i(e_dstM), .d_srcA_i(srcA), .d_srcB_i(srcB), .e_Cnd_i(cnd),
    .m_stat_i(m_stat), .W_stat_i(w_stat),
    .F_predPC_o(pc), .F_stall_o(fs), .D_stall_o(ds), .W_stall_o(ws),
    .D_bubble_o(db), .E_bubble_o(eb), .M_bubble_o(mb), .halted_o(halted),
    .cycle_cnt_o(cyc), .stall_cnt_o(stl), .mispred_cnt_o(mis)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .f_predPC_i(f_predPC),
    .D_icode_i(d_icode), .E_icode_i(e_icode), .M_icode_i(m_icode),
    .E_dstM_i(e_dstM), .d_srcA_i(srcA), .d_srcB_i(srcB), .e_Cnd_i(cnd),
    .m_stat_i(m_stat), .W_stat_i(w_stat),
    .F_predPC_o(pc4), .F_stall_o(fs4), .D_stall_o(ds4), .W_stall_o(ws4),
    .D_bubble_o(db4), .E_bubble_o(eb4), .M_bubble_o(mb4), .halted_o(halted4),
    .cycle_cnt_o(cyc4), .stall_cnt_o(stl4), .mispred_cnt_o(mis4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint n, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  // Reference model: mode flags plus raw event counts; saturation applied at compare time.
  bit      halt_m, drain_m;
  logic [63:0] pred_m;
  longint  n_cyc, n_stall, n_mis;
  logic    lu, rp, mp, mx, wx;
  logic    e_fs, e_ds, e_ws, e_db, e_eb, e_mb;

  always_comb begin
    lu = (e_icode == 4'h5 || e_icode == 4'hB) && e_dstM != 4'hF &&
         (e_dstM == srcA || e_dstM == srcB);
    rp = (d_icode == 4'h9) || (e_icode == 4'h9) || (m_icode == 4'h9);
    mp = (e_icode == 4'h7) && !cnd;
    mx = (m_stat != 3'd1);
    wx = (w_stat != 3'd1);
    e_fs = 1'b0; e_ds = 1'b0; e_ws = 1'b0; e_db = 1'b0; e_eb = 1'b0; e_mb = 1'b0;
    if (halt_m) begin
      e_fs = 1'b1; e_ds = 1'b1; e_ws = 1'b1; e_mb = 1'b1;
    end else if (drain_m) begin
      e_fs = 1'b1; e_db = 1'b1; e_eb = 1'b1; e_mb = 1'b1; e_ws = wx;
    end else begin
      e_fs = lu || rp;
      e_ds = lu;
      e_db = (mp || rp) && !lu;
      e_eb = mp || lu;
      e_mb = mx || wx;
      e_ws = wx;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_m <= 1'b0; drain_m <= 1'b0; pred_m <= '0;
      n_cyc <= 0; n_stall <= 0; n_mis <= 0;
    end else begin
      if (!halt_m) n_cyc <= n_cyc + 1;
      if (!halt_m && !drain_m && e_fs) n_stall <= n_stall + 1;
      if (!halt_m && !drain_m && mp) n_mis <= n_mis + 1;
      if (!e_fs) pred_m <= f_predPC;
      if (!halt_m) begin
        if (wx) begin halt_m <= 1'b1; drain_m <= 1'b0; end
        else if (mx) drain_m <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("F_stall", fs, e_fs);
      chk("D_stall", ds, e_ds);
      chk("W_stall", ws, e_ws);
      chk("D_bubble", db, e_db);
      chk("E_bubble", eb, e_eb);
      chk("M_bubble", mb, e_mb);
      chk("stall_vs_bubble", ds && db, 1'b0);
      chk("halted", halted, halt_m);
      chk("F_predPC", pc, pred_m);
      chk("cycle_cnt", cyc, sat(n_cyc, 32));
      chk("stall_cnt", stl, sat(n_stall, 32));
      chk("mispred_cnt", mis, sat(n_mis, 32));
      chk("cycle_cnt4", cyc4, sat(n_cyc, 4));
      chk("stall_cnt4", stl4, sat(n_stall, 4));
      chk("mispred_cnt4", mis4, sat(n_mis, 4));
    end
  end

  task automatic nop_inputs();
    d_icode = 4'h1; e_icode = 4'h1; m_icode = 4'h1;
    e_dstM = 4'hF; srcA = 4'hF; srcB = 4'hF; cnd = 1'b1;
    m_stat = 3'd1; w_stat = 3'd1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    f_predPC = 64'h100;
    nop_inputs();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 64'h0);
    chk("rst_cyc", cyc, 0);
    chk("rst_halted", halted, 1'b0);
    next_cycle(); rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rel_pc", pc, 64'h100);
    chk("rel_cyc", cyc, 1);

    // load-use hazard on rA
    next_cycle(); e_icode = 4'h5; e_dstM = 4'd3; srcA = 4'd3; f_predPC = 64'h200;
    @(negedge clk);
    chk("lu_fs", fs, 1'b1); chk("lu_ds", ds, 1'b1);
    chk("lu_eb", eb, 1'b1); chk("lu_db", db, 1'b0);
    next_cycle(); nop_inputs();
    @(negedge clk);
    chk("lu_pc_hold", pc, 64'h100);
    chk("lu_stall_cnt", stl, 1);

    // RET walking through D, E, M
    for (int k = 0; k < 3; k++) begin
      next_cycle(); nop_inputs();
      if (k == 0) d_icode = 4'h9;
      if (k == 1) e_icode = 4'h9;
      if (k == 2) m_icode = 4'h9;
      @(negedge clk);
      chk("ret_fs", fs, 1'b1); chk("ret_db", db, 1'b1);
    end
    next_cycle(); nop_inputs();
    @(negedge clk);
    chk("ret_w_fs", fs, 1'b0);
    chk("ret_stall_cnt", stl, 4);

    // mispredict, then mispredict with RET in D
    next_cycle(); e_icode = 4'h7; cnd = 1'b0;
    @(negedge clk);
    chk("mp_db", db, 1'b1); chk("mp_eb", eb, 1'b1); chk("mp_fs", fs, 1'b0);
    next_cycle(); d_icode = 4'h9;
    @(negedge clk);
    chk("mp_cnt1", mis, 1);
    chk("mpret_db", db, 1'b1); chk("mpret_fs", fs, 1'b1); chk("mpret_ds", ds, 1'b0);
    next_cycle(); nop_inputs();
    @(negedge clk);
    chk("mp_cnt2", mis, 2);
    chk("mp_stall_cnt", stl, 5);

    // memory exception, drain, then W exception and halt
    next_cycle(); m_stat = 3'd2; f_predPC = 64'h300;
    @(negedge clk);
    chk("mexc_mb", mb, 1'b1);
    next_cycle(); m_stat = 3'd1; e_icode = 4'h7; cnd = 1'b0;
    @(negedge clk);
    chk("drain_fs", fs, 1'b1); chk("drain_db", db, 1'b1); chk("drain_eb", eb, 1'b1);
    chk("drain_ds", ds, 1'b0); chk("drain_ws", ws, 1'b0);
    next_cycle(); w_stat = 3'd2;
    @(negedge clk);
    chk("wexc_ws", ws, 1'b1); chk("wexc_halted", halted, 1'b0);
    next_cycle(); w_stat = 3'd1;
    @(negedge clk);
    chk("halt_halted", halted, 1'b1);
    chk("halt_db", db, 1'b0); chk("halt_ds", ds, 1'b1);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("halt_stall_frozen", stl, 5);
    chk("halt_mis_frozen", mis, 2);

    // reset out of HALT is immediate
    #1 rst_n = 1'b0;
    #1;
    chk("arst_halted", halted, 1'b0);
    chk("arst_cyc", cyc, 0);
    nop_inputs();
    next_cycle(); rst_n = 1'b1;

    // saturation of the narrow instance
    repeat (20) next_cycle();
    @(negedge clk);
    chk("sat_cyc4", cyc4, 4'd15);
    chk("sat_cyc32", cyc, 20);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("sat_cyc4_hold", cyc4, 4'd15);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

endmodule
